downsample_frame_arbiter: RTL and testbench
===========================================

Name: downsample_frame_arbiter

Overview:
Shares one downsample datapath between NUM_IN independent pixel streams.
- The downsampler keeps raster x/y position state, so ownership is granted per whole frame, never per pixel.
- Selection is round-robin.
- Sits between the stream sources and the downsampler's data_in valid/ready interface.
- Reports which stream currently owns the datapath, and pulses on each frame completion.

Parameters:
NUM_IN, 2, number of requesting streams (>=2)
WIDTH, 16, pixel data width
FRAME_PIXELS, 1024, pixels per frame (32x32 raster); count width CW = clog2(FRAME_PIXELS)
IDW, clog2(NUM_IN), width of grant_id (derived, not overridable)

Ports:
CLK  input  1  clock, rising edge
RESETN  input  1  asynchronous active-low reset
in_valid  input  NUM_IN  per-stream valid; bit i asserted = stream i has a pixel/request
in_data  input  NUM_IN*WIDTH  stream i occupies bits [i*WIDTH +: WIDTH]
in_ready  output  NUM_IN  per-stream ready
data_out_valid  output  1  to downsampler data_in_valid
data_out_data  output  WIDTH  to downsampler data_in_data
data_out_ready  input  1  from downsampler data_in_ready
grant_valid  output  1  a stream currently owns the datapath
grant_id  output  IDW  index of owning stream
frame_done  output  1  one-cycle pulse after the last pixel of a frame transfers

Behaviour:
- One clock, CLK. RESETN is asynchronous and active-low.
- Reset values: state=IDLE, grant_valid=0, grant_id=0, last_id=NUM_IN-1 (stream 0 has first priority), pix_cnt=0, frame_done=0.
- States:
  - IDLE: no owner.
  - OWN: grant_id streams a frame.
- Combinational datapath, zero latency:
  - data_out_valid = grant_valid & in_valid[grant_id]
  - data_out_data = in_data slice grant_id (don't-care when not granted)
  - in_ready[i] = grant_valid & (i==grant_id) & data_out_ready; non-owners always see ready=0
- Handshake: a transfer occurs when data_out_valid & data_out_ready. Only transfers advance pix_cnt.
- IDLE -> OWN, when any in_valid bit is set:
  - Register grant_id = first requester searching last_id+1, last_id+2, ... modulo NUM_IN.
  - Set grant_valid=1 and enter OWN on the next edge.
  - No pixel transfers in the IDLE cycle.
- OWN:
  - Ownership is held even if the owner deasserts in_valid mid-frame; the datapath simply stalls. No timeout.
  - Each transfer increments pix_cnt.
  - On the transfer with pix_cnt==FRAME_PIXELS-1:
    - pix_cnt<=0, grant_valid<=0, last_id<=grant_id, state<=IDLE
    - frame_done<=1 for exactly one cycle (the IDLE cycle)
- Minimum gap between frames: exactly one cycle (the IDLE arbitration cycle). Back-to-back frames from a stream, or alternating streams, therefore take FRAME_PIXELS+1 cycles each at full throughput.
- Fairness: with all streams requesting continuously, grants rotate 0,1,...,NUM_IN-1,0,...
- Single requester: it is re-granted after each frame, with a one-cycle gap.
- grant_id holds its last value while grant_valid=0.
- Wrap-around:
  - pix_cnt never exceeds FRAME_PIXELS-1.
  - The round-robin search wraps modulo NUM_IN, including non-power-of-2 NUM_IN; unused id codes are never produced.
- Simultaneous events: new requests arriving in the same cycle as a frame-completing transfer are only considered in the following IDLE cycle.
- Reset mid-frame:
  - Returns immediately to the reset values; the partial frame is abandoned and no frame_done is issued.
  - The system must also reset the downstream downsampler position state.

Test Plan:
1. Reset, stream 0 valid alone, data_out_ready=1, FRAME_PIXELS=1024 -> grant_valid=1, grant_id=0 one cycle after valid. 1024 transfers in 1024 consecutive cycles. frame_done pulses one cycle. Re-grant to 0 after one IDLE cycle.
2. NUM_IN=3, all streams valid continuously -> grant_id sequence 0,1,2,0 across four frames. Exactly one idle cycle between frames. in_ready is never asserted for a non-owner.
3. Owner drops in_valid for 10 cycles at pixel 500 while stream 1 is requesting -> no transfers and no regrant during the gap. Frame completes after 1024 total transfers, then grant moves to 1.
4. data_out_ready toggles 1/0 every cycle -> pix_cnt advances only on handshake cycles. frame_done occurs after the 1024th handshake. Data order is preserved and equals the owner's in_data.
5. RESETN asserted asynchronously (between edges) at pixel 300 -> grant_valid=0, frame_done=0 immediately. After release, stream 0 has first priority and pix_cnt restarts at 0.
6. Stream 1 asserts valid in the same cycle as stream 0's final transfer -> stream 1 is granted after the IDLE cycle (last_id=0). frame_done and the grant decision happen in the same cycle.

Source files
------------

// File: rtl/downsample_frame_arbiter.sv
// downsample_frame_arbiter: frame-granular round-robin arbiter that shares one downsample datapath.
// Ports:
//   i_clk, i_resetn                      clock, asynchronous active-low reset
//   i_in_valid/i_in_data, o_in_ready     NUM_IN source streams, stream i at i_in_data[i*WIDTH +: WIDTH]
//   o_data_out_*, i_data_out_ready       valid/ready link into the downsampler
//   o_grant_valid, o_grant_id            current frame owner
//   o_frame_done                         one-cycle pulse after a frame's last pixel transfers
module downsample_frame_arbiter #(
  parameter int NUM_IN = 2,
  parameter int WIDTH = 16,
  parameter int FRAME_PIXELS = 1024,
  localparam int IDW = $clog2(NUM_IN)
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic [NUM_IN-1:0]       i_in_valid,
  input  logic [NUM_IN*WIDTH-1:0] i_in_data,
  output logic [NUM_IN-1:0]       o_in_ready,
  output logic                    o_data_out_valid,
  output logic [WIDTH-1:0]        o_data_out_data,
  input  logic                    i_data_out_ready,
  output logic                    o_grant_valid,
  output logic [IDW-1:0]          o_grant_id,
  output logic                    o_frame_done
);
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  typedef enum logic {IDLE, OWN} state_t;
  state_t r_state, w_state_nxt;
  logic [IDW-1:0] r_grant_id, r_last_id, w_pick;
  logic [CW-1:0] r_pix_cnt;
  logic r_frame_done, w_any, w_xfer, w_last;
  assign o_grant_valid = r_state == OWN;
  assign o_grant_id = r_grant_id;
  assign o_frame_done = r_frame_done;
  assign o_data_out_valid = o_grant_valid & i_in_valid[r_grant_id];
  assign o_data_out_data = i_in_data[r_grant_id*WIDTH +: WIDTH];
  assign o_in_ready = {{(NUM_IN-1){1'b0}}, o_grant_valid & i_data_out_ready} << r_grant_id;
  assign w_any = |i_in_valid;
  assign w_xfer = o_data_out_valid & i_data_out_ready;
  assign w_last = w_xfer && r_pix_cnt == CW'(FRAME_PIXELS - 1);
  // Round-robin pick: the requester at the smallest distance past r_last_id wins.
  always_comb begin
    int d;
    int best;
    w_pick = r_grant_id;
    best = NUM_IN;
    for (int j = 0; j < NUM_IN; j++) begin
      d = (j + NUM_IN - 1 - int'(r_last_id)) % NUM_IN;
      if (i_in_valid[j] && d < best) begin
        best = d;
        w_pick = IDW'(j);
      end
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE) ? (w_any ? OWN : IDLE) : (w_last ? IDLE : OWN);
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_grant_id <= '0;
      r_last_id <= IDW'(NUM_IN - 1);
      r_pix_cnt <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last;
      if (r_state == IDLE && w_any) r_grant_id <= w_pick;
      if (w_xfer) r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
      if (w_last) r_last_id <= r_grant_id;
    end
  end
endmodule

// File: tb/tb_downsample_frame_arbiter.sv
// tb_downsample_frame_arbiter: directed bench with a frame-level reference model for downsample_frame_arbiter.
module tb_downsample_frame_arbiter;
  localparam int N = 3;
  localparam int W = 16;
  localparam int FP = 1024;
  logic clk, rst_n, ready;
  logic [N-1:0] in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic dv, gv, fd;
  logic [W-1:0] dd;
  logic [1:0] gid;
  int n_vec = 0;
  int n_err = 0;
  int xfers = 0;
  logic [W-1:0] last_data;
  int src_idx [N];

  downsample_frame_arbiter #(.NUM_IN(N), .WIDTH(W), .FRAME_PIXELS(FP)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_data_out_valid(dv), .o_data_out_data(dd),
    .i_data_out_ready(ready), .o_grant_valid(gv), .o_grant_id(gid), .o_frame_done(fd)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sources: stream i sends {i, pixel index}; the index advances on each accepted pixel.
  initial begin
    logic [N-1:0] tk;
    logic rs;
    for (int i = 0; i < N; i++) src_idx[i] = 0;
    in_data = '0;
    forever begin
      @(negedge clk);
      tk = in_ready & in_valid;
      rs = rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n || !rs) src_idx[i] = 0;
        else if (tk[i]) src_idx[i]++;
        in_data[i*W +: W] = W'((i << 14) | (src_idx[i] & 16'h3fff));
      end
    end
  end

  // Reference model: frame-level owner/count bookkeeping, checked every cycle.
  bit m_gv, m_done, exp_dv, nd;
  int m_gid, m_last, m_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_gv = 0; m_gid = 0; m_last = N - 1; m_cnt = 0; m_done = 0;
    end
    exp_dv = m_gv && in_valid[m_gid];
    chk("grant_valid", 32'(gv), 32'(m_gv));
    chk("grant_id", 32'(gid), 32'(m_gid));
    chk("frame_done", 32'(fd), 32'(m_done));
    chk("data_out_valid", 32'(dv), 32'(exp_dv));
    chk("in_ready", 32'(in_ready), (m_gv && ready) ? (32'd1 << m_gid) : 32'd0);
    if (exp_dv) chk("data_out_data", 32'(dd), 32'(in_data[m_gid*W +: W]));
    if (dv && ready) begin
      xfers++;
      last_data = dd;
    end
    if (rst_n) begin
      nd = 0;
      if (!m_gv) begin
        for (int k = 1; k <= N; k++)
          if (in_valid[(m_last + k) % N]) begin
            m_gid = (m_last + k) % N;
            m_gv = 1;
            break;
          end
      end else if (exp_dv && ready) begin
        m_cnt++;
        if (m_cnt == FP) begin
          m_cnt = 0; m_gv = 0; m_last = m_gid; nd = 1;
        end
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    rst_n = 0;
    in_valid = '0;
    ready = 1;
    repeat (2) step();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!fd && n < 5000) begin
      step();
      n++;
    end
    if (!fd) chk("timeout_frame_done", 0, 1);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfers < target && n < 5000) begin
      step();
      n++;
    end
    if (xfers < target) chk("timeout_xfers", 32'(xfers), 32'(target));
  endtask

  initial begin
    int n, base;
    rst_n = 0;
    in_valid = '0;
    ready = 1;
    // 1: single requester, full throughput, re-grant after one idle cycle
    apply_reset();
    chk("rst_grant_valid", 32'(gv), 0);
    chk("rst_grant_id", 32'(gid), 0);
    chk("rst_frame_done", 32'(fd), 0);
    rst_n = 1;
    in_valid = 3'b001;
    chk("t1_idle_no_grant", 32'(gv), 0);
    step();
    chk("t1_grant_valid", 32'(gv), 1);
    chk("t1_grant_id", 32'(gid), 0);
    base = xfers;
    wait_done(n);
    chk("t1_frame_cycles", 32'(n), 1024);
    chk("t1_xfers", 32'(xfers - base), 1024);
    chk("t1_idle_gap", 32'(gv), 0);
    step();
    chk("t1_done_pulse_width", 32'(fd), 0);
    chk("t1_regrant_valid", 32'(gv), 1);
    chk("t1_regrant_id", 32'(gid), 0);
    // 2: all three request continuously, grants rotate 0,1,2,0
    apply_reset();
    rst_n = 1;
    in_valid = 3'b111;
    step();
    for (int f = 0; f < 4; f++) begin
      chk("t2_grant_valid", 32'(gv), 1);
      chk("t2_grant_id", 32'(gid), 32'(f % 3));
      wait_done(n);
      chk("t2_frame_cycles", 32'(n), 1024);
      chk("t2_one_idle", 32'(gv), 0);
      step();
    end
    // 3: owner stalls for 10 cycles at pixel 500, no regrant in the gap
    apply_reset();
    rst_n = 1;
    in_valid = 3'b011;
    step();
    base = xfers;
    wait_xfers(base + 500);
    in_valid = 3'b010;
    repeat (10) step();
    chk("t3_stall_no_xfer", 32'(xfers - base), 500);
    chk("t3_stall_owner", 32'(gid), 0);
    chk("t3_stall_valid", 32'(gv), 1);
    in_valid = 3'b011;
    wait_done(n);
    chk("t3_total_xfers", 32'(xfers - base), 1024);
    step();
    chk("t3_next_owner", 32'(gid), 1);
    // 4: downstream ready toggles every cycle
    apply_reset();
    rst_n = 1;
    in_valid = 3'b001;
    step();
    base = xfers;
    n = 0;
    while (!fd && n < 5000) begin
      ready = ~ready;
      step();
      n++;
    end
    if (!fd) chk("timeout_t4", 0, 1);
    chk("t4_xfers", 32'(xfers - base), 1024);
    chk("t4_last_data", 32'(last_data), 32'd1023);
    ready = 1;
    // 5: async reset at pixel 300 of stream 1's frame
    apply_reset();
    rst_n = 1;
    in_valid = 3'b001;
    step();
    wait_done(n);
    in_valid = 3'b011;
    step();
    chk("t5_owner1", 32'(gid), 1);
    base = xfers;
    wait_xfers(base + 300);
    #3;
    rst_n = 0;
    #1;
    chk("t5_async_grant_valid", 32'(gv), 0);
    chk("t5_async_frame_done", 32'(fd), 0);
    chk("t5_async_dv", 32'(dv), 0);
    chk("t5_async_in_ready", 32'(in_ready), 0);
    step();
    rst_n = 1;
    base = xfers;
    step();
    chk("t5_priority0", 32'(gid), 0);
    wait_done(n);
    chk("t5_restart_xfers", 32'(xfers - base), 1024);
    // 6: stream 1 requests during stream 0's final transfer
    apply_reset();
    rst_n = 1;
    in_valid = 3'b001;
    step();
    base = xfers;
    wait_xfers(base + 1023);
    in_valid = 3'b011;
    step();
    chk("t6_frame_done", 32'(fd), 1);
    chk("t6_idle", 32'(gv), 0);
    step();
    chk("t6_grant_valid", 32'(gv), 1);
    chk("t6_grant_id", 32'(gid), 1);
    chk("t6_done_cleared", 32'(fd), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
